// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the ecap5 data-processor bus fabric.
package ecap5_dproc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M0 = 2'd1,
    GRANT_M1 = 2'd2,
    ABORT    = 2'd3
  } arb_state_t;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  function automatic arb_state_t grant_state(input logic id);
    return (id == ARB_M1) ? GRANT_M1 : GRANT_M0;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes
// to the master opposite the one granted last.
module rr_arbiter2
  import ecap5_dproc_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       grant
);

  always_comb begin
    valid = |req;
    grant = ARB_M0;
    case (req)
      2'b01:   grant = ARB_M0;
      2'b10:   grant = ARB_M1;
      2'b11:   grant = (last == ARB_M0) ? ARB_M1 : ARB_M0;
      default: grant = ARB_M0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master pipelined Wishbone arbiter with round-robin tie breaking and an
// ack watchdog that aborts cycles the slave never answers.
module bus_arbiter
  import ecap5_dproc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  output logic [31:0] m0_wb_dat_o,
  input  logic        m0_wb_we_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_cyc_i,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_stall_o,
  output logic        m0_wb_err_o,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  output logic [31:0] m1_wb_dat_o,
  input  logic        m1_wb_we_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_cyc_i,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_stall_o,
  output logic        m1_wb_err_o,
  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  output logic        s_wb_we_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_cyc_o,
  input  logic        s_wb_stall_i,
  input  logic        s_wb_ack_i,
  input  logic [31:0] s_wb_dat_i
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] TIMEOUT_LAST  = TIMEOUT_LIMIT - 16'd1;
  localparam bit          WDOG_EN       = (TIMEOUT_CYCLES != 0);

  arb_state_t  state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [15:0] timer_q, timer_d;
  logic        err_q, err_d;
  logic        owner_cyc;
  logic        rearb;
  logic        pick_valid;
  logic        pick_id;

  rr_arbiter2 u_rr (
    .req   ({m1_wb_cyc_i, m0_wb_cyc_i}),
    .last  (last_q),
    .valid (pick_valid),
    .grant (pick_id)
  );

  assign owner_cyc = (owner_q == ARB_M1) ? m1_wb_cyc_i : m0_wb_cyc_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= ARB_M1;
      owner_q <= ARB_M0;
      timer_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // Releasing the bus re-arbitrates in the same cycle, so handover needs no idle bubble.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    rearb   = 1'b0;
    case (state_q)
      IDLE: rearb = 1'b1;
      GRANT_M0, GRANT_M1: begin
        if (!owner_cyc) begin
          rearb = 1'b1;
        end else if (s_wb_ack_i) begin
          timer_d = 16'd0;
        end else if (WDOG_EN && (timer_q == TIMEOUT_LAST)) begin
          state_d = ABORT;
          err_d   = 1'b1;
        end else if (timer_q < TIMEOUT_LIMIT) begin
          timer_d = timer_q + 16'd1;
        end
      end
      ABORT: rearb = !owner_cyc;
      default: rearb = 1'b1;
    endcase
    if (rearb) begin
      timer_d = 16'd0;
      if (pick_valid) begin
        state_d = grant_state(pick_id);
        last_d  = pick_id;
        owner_d = pick_id;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // The slave mux selects on the registered state only, keeping s_wb_cyc_o glitch-free.
  always_comb begin
    s_wb_adr_o    = 32'd0;
    s_wb_dat_o    = 32'd0;
    s_wb_we_o     = 1'b0;
    s_wb_sel_o    = 4'd0;
    s_wb_stb_o    = 1'b0;
    s_wb_cyc_o    = 1'b0;
    m0_wb_stall_o = 1'b1;
    m1_wb_stall_o = 1'b1;
    m0_wb_ack_o   = 1'b0;
    m1_wb_ack_o   = 1'b0;
    case (state_q)
      GRANT_M0: begin
        s_wb_adr_o    = m0_wb_adr_i;
        s_wb_dat_o    = m0_wb_dat_i;
        s_wb_we_o     = m0_wb_we_i;
        s_wb_sel_o    = m0_wb_sel_i;
        s_wb_stb_o    = m0_wb_stb_i;
        s_wb_cyc_o    = m0_wb_cyc_i;
        m0_wb_stall_o = s_wb_stall_i;
        m0_wb_ack_o   = s_wb_ack_i;
      end
      GRANT_M1: begin
        s_wb_adr_o    = m1_wb_adr_i;
        s_wb_dat_o    = m1_wb_dat_i;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_sel_o    = m1_wb_sel_i;
        s_wb_stb_o    = m1_wb_stb_i;
        s_wb_cyc_o    = m1_wb_cyc_i;
        m1_wb_stall_o = s_wb_stall_i;
        m1_wb_ack_o   = s_wb_ack_i;
      end
      default: ;
    endcase
  end

  assign m0_wb_err_o = err_q && (owner_q == ARB_M0);
  assign m1_wb_err_o = err_q && (owner_q == ARB_M1);
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with a short watchdog (4 cycles).
module tb_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_wb_adr_i, m0_wb_dat_i, m0_wb_dat_o;
  logic        m0_wb_we_i, m0_wb_stb_i, m0_wb_cyc_i;
  logic [3:0]  m0_wb_sel_i;
  logic        m0_wb_ack_o, m0_wb_stall_o, m0_wb_err_o;
  logic [31:0] m1_wb_adr_i, m1_wb_dat_i, m1_wb_dat_o;
  logic        m1_wb_we_i, m1_wb_stb_i, m1_wb_cyc_i;
  logic [3:0]  m1_wb_sel_i;
  logic        m1_wb_ack_o, m1_wb_stall_o, m1_wb_err_o;
  logic [31:0] s_wb_adr_o, s_wb_dat_o, s_wb_dat_i;
  logic        s_wb_we_o, s_wb_stb_o, s_wb_cyc_o;
  logic [3:0]  s_wb_sel_o;
  logic        s_wb_stall_i, s_wb_ack_i;

  int checks = 0;
  int errors = 0;
  logic exp_owner;

  always #5 clk_i = ~clk_i;

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i, .rst_i,
    .m0_wb_adr_i, .m0_wb_dat_i, .m0_wb_dat_o, .m0_wb_we_i, .m0_wb_sel_i,
    .m0_wb_stb_i, .m0_wb_cyc_i, .m0_wb_ack_o, .m0_wb_stall_o, .m0_wb_err_o,
    .m1_wb_adr_i, .m1_wb_dat_i, .m1_wb_dat_o, .m1_wb_we_i, .m1_wb_sel_i,
    .m1_wb_stb_i, .m1_wb_cyc_i, .m1_wb_ack_o, .m1_wb_stall_o, .m1_wb_err_o,
    .s_wb_adr_o, .s_wb_dat_o, .s_wb_we_o, .s_wb_sel_o, .s_wb_stb_o, .s_wb_cyc_o,
    .s_wb_stall_i, .s_wb_ack_i, .s_wb_dat_i
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_wb_adr_i = 32'd0; m0_wb_dat_i = 32'd0; m0_wb_we_i = 1'b0; m0_wb_sel_i = 4'd0;
    m0_wb_stb_i = 1'b0;  m0_wb_cyc_i = 1'b0;
    m1_wb_adr_i = 32'd0; m1_wb_dat_i = 32'd0; m1_wb_we_i = 1'b0; m1_wb_sel_i = 4'd0;
    m1_wb_stb_i = 1'b0;  m1_wb_cyc_i = 1'b0;
    s_wb_stall_i = 1'b0; s_wb_ack_i = 1'b0;
  endtask

  initial begin
    clear_inputs();
    s_wb_dat_i = 32'hCAFE_0001;
    rst_i = 1'b0;
    #2;
    check_output("rst_s_cyc", s_wb_cyc_o, 0);
    check_output("rst_m0_stall", m0_wb_stall_o, 1);
    check_output("rst_m1_stall", m1_wb_stall_o, 1);
    check_output("rst_m0_err", m0_wb_err_o, 0);
    check_output("rst_m1_dat", m1_wb_dat_o, 32'hCAFE_0001);
    tick();
    tick();
    rst_i = 1'b1;

    // Single m0 read, acked two cycles after the address phase.
    m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_adr_i = 32'h0000_1000;
    settle();
    check_output("t1_req_stall", m0_wb_stall_o, 1);
    check_output("t1_req_s_cyc", s_wb_cyc_o, 0);
    tick();
    settle();
    check_output("t1_s_adr", s_wb_adr_o, 32'h0000_1000);
    check_output("t1_s_stb", s_wb_stb_o, 1);
    check_output("t1_m0_stall", m0_wb_stall_o, 0);
    check_output("t1_m1_stall_a", m1_wb_stall_o, 1);
    tick();
    m0_wb_stb_i = 1'b0;
    settle();
    check_output("t1_s_stb_low", s_wb_stb_o, 0);
    check_output("t1_m0_ack_early", m0_wb_ack_o, 0);
    tick();
    s_wb_ack_i = 1'b1; s_wb_dat_i = 32'hDEAD_BEEF;
    settle();
    check_output("t1_m0_ack", m0_wb_ack_o, 1);
    check_output("t1_m0_dat", m0_wb_dat_o, 32'hDEAD_BEEF);
    check_output("t1_m1_ack", m1_wb_ack_o, 0);
    check_output("t1_m1_stall_b", m1_wb_stall_o, 1);
    tick();
    s_wb_ack_i = 1'b0; m0_wb_cyc_i = 1'b0;
    tick();
    settle();
    check_output("t1_idle_s_cyc", s_wb_cyc_o, 0);
    check_output("t1_idle_m0_stall", m0_wb_stall_o, 1);

    // Reset restores last=M1, so a tie right after reset goes to m0.
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_adr_i = 32'h0000_2000;
    m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1; m1_wb_adr_i = 32'h0000_3000;
    tick();
    s_wb_ack_i = 1'b1;
    settle();
    check_output("t2_first_adr", s_wb_adr_o, 32'h0000_2000);
    check_output("t2_m1_stall", m1_wb_stall_o, 1);
    check_output("t2_m0_ack", m0_wb_ack_o, 1);
    tick();
    s_wb_ack_i = 1'b0; m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0;
    tick();
    s_wb_ack_i = 1'b1;
    settle();
    check_output("t2_handover_adr", s_wb_adr_o, 32'h0000_3000);
    check_output("t2_handover_cyc", s_wb_cyc_o, 1);
    check_output("t2_m1_ack", m1_wb_ack_o, 1);
    check_output("t2_m0_stall", m0_wb_stall_o, 1);
    tick();
    clear_inputs();
    tick();

    // Continuous contention: each owner drops cyc for one cycle after its ack.
    m0_wb_adr_i = 32'h0000_A000; m1_wb_adr_i = 32'h0000_B000;
    m0_wb_cyc_i = 1'b1; m1_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m1_wb_stb_i = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      exp_owner = (i % 2) == 1;
      m0_wb_cyc_i = 1'b1; m1_wb_cyc_i = 1'b1; s_wb_ack_i = 1'b1;
      settle();
      check_output($sformatf("t3_adr_%0d", i), s_wb_adr_o,
                   exp_owner ? 32'h0000_B000 : 32'h0000_A000);
      check_output($sformatf("t3_m0_stall_%0d", i), m0_wb_stall_o, exp_owner ? 1 : 0);
      check_output($sformatf("t3_m1_ack_%0d", i), m1_wb_ack_o, exp_owner ? 1 : 0);
      tick();
      s_wb_ack_i = 1'b0;
      if (exp_owner) m1_wb_cyc_i = 1'b0;
      else m0_wb_cyc_i = 1'b0;
      tick();
    end
    settle();
    check_output("t3_seventh_adr", s_wb_adr_o, 32'h0000_A000);
    m0_wb_cyc_i = 1'b0;
    tick();
    m0_wb_cyc_i = 1'b1; m1_wb_cyc_i = 1'b1;
    tick();
    s_wb_ack_i = 1'b1;
    settle();
    check_output("t3_tie_after_m0", s_wb_adr_o, 32'h0000_B000);
    tick();
    clear_inputs();
    tick();

    // Watchdog: m1 never acked, abort after four grant cycles.
    m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1; m1_wb_adr_i = 32'h0000_C000;
    tick();
    settle();
    check_output("t4_grant_cyc", s_wb_cyc_o, 1);
    check_output("t4_grant_stall", m1_wb_stall_o, 0);
    m1_wb_stb_i = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      settle();
      check_output($sformatf("t4_wait_cyc_%0d", i), s_wb_cyc_o, 1);
      check_output($sformatf("t4_wait_err_%0d", i), m1_wb_err_o, 0);
    end
    tick();
    settle();
    check_output("t4_abort_cyc", s_wb_cyc_o, 0);
    check_output("t4_abort_err", m1_wb_err_o, 1);
    check_output("t4_abort_m0_err", m0_wb_err_o, 0);
    check_output("t4_abort_stall", m1_wb_stall_o, 1);
    tick();
    m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_adr_i = 32'h0000_D000;
    settle();
    check_output("t4_err_pulse_end", m1_wb_err_o, 0);
    tick();
    settle();
    check_output("t4_abort_holds_m0", m0_wb_stall_o, 1);
    check_output("t4_abort_holds_cyc", s_wb_cyc_o, 0);
    m1_wb_cyc_i = 1'b0;
    tick();
    s_wb_ack_i = 1'b1;
    settle();
    check_output("t4_after_abort_adr", s_wb_adr_o, 32'h0000_D000);
    check_output("t4_after_abort_ack", m0_wb_ack_o, 1);
    tick();
    clear_inputs();
    tick();

    // Ack landing in the timeout cycle beats the watchdog.
    m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_adr_i = 32'h0000_E000;
    tick();
    m0_wb_stb_i = 1'b0;
    tick();
    tick();
    tick();
    s_wb_ack_i = 1'b1;
    settle();
    check_output("t5_ack_in_timeout", m0_wb_ack_o, 1);
    tick();
    s_wb_ack_i = 1'b0;
    settle();
    check_output("t5_no_abort_cyc", s_wb_cyc_o, 1);
    check_output("t5_no_err", m0_wb_err_o, 0);
    check_output("t5_still_owner", m0_wb_stall_o, 0);
    tick();
    clear_inputs();
    tick();

    // Asynchronous reset in the middle of an m1 write waiting for ack.
    m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1; m1_wb_we_i = 1'b1; m1_wb_sel_i = 4'hF;
    m1_wb_adr_i = 32'h0000_F000; m1_wb_dat_i = 32'h1234_5678;
    tick();
    s_wb_ack_i = 1'b1; s_wb_dat_i = 32'h0BAD_F00D;
    settle();
    check_output("t6_pre_we", s_wb_we_o, 1);
    check_output("t6_pre_dat", s_wb_dat_o, 32'h1234_5678);
    #2;
    rst_i = 1'b0;
    #1;
    check_output("t6_rst_cyc", s_wb_cyc_o, 0);
    check_output("t6_rst_adr", s_wb_adr_o, 0);
    check_output("t6_rst_dat", s_wb_dat_o, 0);
    check_output("t6_rst_sel", s_wb_sel_o, 0);
    check_output("t6_rst_we", s_wb_we_o, 0);
    check_output("t6_rst_m1_ack", m1_wb_ack_o, 0);
    check_output("t6_rst_m1_stall", m1_wb_stall_o, 1);
    check_output("t6_rst_m1_dat", m1_wb_dat_o, 32'h0BAD_F00D);
    tick();
    rst_i = 1'b1;
    s_wb_ack_i = 1'b0;
    m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_adr_i = 32'h0000_0100;
    tick();
    settle();
    check_output("t6_tie_to_m0", s_wb_adr_o, 32'h0000_0100);
    check_output("t6_m1_waits", m1_wb_stall_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave Wishbone (pipelined) arbiter that shares the single memory port between the instruction fetch master (m0) and the load/store master (m1). It sits between the two front-end masters and the memory interconnect. Ownership is granted per bus cycle (`cyc`) with round-robin fairness on contention. A watchdog aborts cycles whose acknowledge never arrives.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles a granted transaction may wait for ack before abort; 0 disables the watchdog.

Ports:
- `clk_i` in 1: single clock, all logic rising-edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `m{0,1}_wb_adr_i` in 32: master address.
- `m{0,1}_wb_dat_i` in 32: master write data.
- `m{0,1}_wb_dat_o` out 32: read data, `s_wb_dat_i` broadcast to both.
- `m{0,1}_wb_we_i` in 1: master write enable.
- `m{0,1}_wb_sel_i` in 4: master byte select.
- `m{0,1}_wb_stb_i` in 1: master strobe.
- `m{0,1}_wb_cyc_i` in 1: master cycle, which is the bus request.
- `m{0,1}_wb_ack_o` out 1: ack routed to owner only.
- `m{0,1}_wb_stall_o` out 1: 1 when not owner, otherwise `s_wb_stall_i`.
- `m{0,1}_wb_err_o` out 1: one-cycle pulse on watchdog abort.
- `s_wb_adr_o` out 32: muxed address.
- `s_wb_dat_o` out 32: muxed write data.
- `s_wb_we_o` out 1: muxed write enable.
- `s_wb_sel_o` out 4: muxed byte select.
- `s_wb_stb_o` out 1: muxed strobe.
- `s_wb_cyc_o` out 1: muxed cycle.
- `s_wb_stall_i` in 1: slave stall.
- `s_wb_ack_i` in 1: slave ack.
- `s_wb_dat_i` in 32: slave read data.

## Operation
- States: IDLE, GRANT_M0, GRANT_M1, ABORT. Registers: `state_q`, `last_q` (last granted master), `owner_q`, `timer_q`.
- Arbitration function, evaluated in IDLE and at release:
  - Only one `cyc_i` high: grant that master.
  - Both high: grant the master opposite `last_q`.
  - Neither high: go to IDLE.
- IDLE -> GRANT_Mx when arbitration selects x. Set `last_q` = x and clear `timer_q`.
- GRANT_Mx -> arbitrate again (zero-bubble handover) when `mx_wb_cyc_i` = 0.
- GRANT_Mx -> ABORT when `timer_q` = `TIMEOUT_CYCLES` - 1 and there is no ack in that cycle, with `TIMEOUT_CYCLES` != 0.
- ABORT -> arbitrate when `m[owner]_wb_cyc_i` = 0.
- Slave-side outputs mirror the owner's inputs combinationally in GRANT_Mx. In IDLE and ABORT all `s_*` outputs are forced to 0.
- Owner stall is `s_wb_stall_i`. The non-owner, and every master in IDLE or ABORT, sees stall = 1 and ack = 0.
- Masters hold `stb_i` and `adr_i` stable while stalled.
- `s_wb_ack_i` outside GRANT state is dropped.
- Ack to the owner is combinational: `mx_ack_o` = `s_wb_ack_i` in GRANT_Mx.
- Watchdog:
  - `timer_q` increments each GRANT cycle with `s_wb_cyc_o` = 1 and no ack. It clears on ack.
  - `timer_q` saturates at `TIMEOUT_CYCLES`, held in 16 bits.
  - On abort, `m[owner]_wb_err_o` pulses for the first ABORT cycle only.
- Simultaneous events:
  - Owner drops `cyc` in the same cycle that the other master raises it: the other is granted at the next edge.
  - Ack in the timeout cycle: the ack wins and there is no abort.
- Reset, asserted at any time, including mid-transaction:
  - Immediate return to IDLE, `last_q` = M1 (so m0 wins the first tie), `timer_q` = 0.
  - All `s_*` outputs 0.
  - `m*_stall_o` = 1, `m*_ack_o` = 0, `m*_err_o` = 0.
  - `m*_dat_o` follows `s_wb_dat_i`.

## Timing
- Grant latency: a request at cycle N in IDLE is visible on `s_*` at cycle N+1. The master is stalled during cycle N.
- Handover: the new owner appears on `s_*` in the cycle after the old owner's `cyc` falls, with no idle cycle.
- Ack and data path: 0 cycles, purely combinational mux.
- Abort timing: with `TIMEOUT_CYCLES` = T, abort is entered T cycles after grant with no ack.
- No `s_wb_cyc_o` glitch: `state_q` is registered, and the mux select uses `state_q` only.

## Structure
- Add to `ecap5_dproc_pkg`:
  - `arb_state_t` enum for the states.
  - `ARB_M0` and `ARB_M1` master-id constants.
- One sub-module, `rr_arbiter2`: purely combinational 2-way round-robin pick (requests, last) -> grant. Everything else stays inline.

## Test plan
- m0 `cyc`/`stb` at adr 0x1000, slave acks 2 cycles later with dat 0xDEADBEEF -> `s_wb_adr_o` = 0x1000 one cycle after the request, m0 ack with data 0xDEADBEEF, m1 stall = 1 throughout.
- Both masters request in the same cycle right after reset -> m0 granted first; after m0 drops `cyc`, m1 is granted on the next cycle with no idle gap.
- Both masters keep requesting back-to-back for 6 cycles -> grants alternate m0, m1, m0, m1...; neither is granted twice in a row.
- `TIMEOUT_CYCLES` = 4, slave never acks m1 -> ABORT after 4 cycles, `s_wb_cyc_o` = 0, one-cycle `m1_wb_err_o`, IDLE after m1 drops `cyc`.
- Slave acks in exactly the timeout cycle -> normal ack to the owner and no `err_o` pulse.
- Reset asserted while GRANT_M1 waits on ack -> all `s_*` outputs 0 immediately (asynchronously), and the next tie goes to m0.
